// File: rtl/check_event_sequencer.sv
//------------------------------------------------------------------------------
// Module      : check_event_sequencer
// Description : Buffers CPU retire events in a FIFO and serialises each one
//               into a header beat plus payload beats on a valid/ready stream
//               toward the checker. Dropped events raise a sticky overflow.
// Options     : define CHK_TRAILER_EN to append an XOR trailer beat per event.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module check_event_sequencer #(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ev_valid,
  input  logic [2:0]    ev_type,
  input  logic [31:0]   rs_value,
  input  logic [31:0]   rt_value,
  input  logic [31:0]   rd_value,
  input  logic [31:0]   branch_addr,
  input  logic [31:0]   jump_addr,
  input  logic [31:0]   lw_data,
  output logic          ev_ready,
  output logic          chk_valid,
  output logic [31:0]   chk_data,
  output logic          chk_last,
  input  logic          chk_ready,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_TRL  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  // FIFO storage: one entry per retired event, payload already packed
  logic [2:0]  r_type_mem [DEPTH];
  logic [2:0]  r_len_mem  [DEPTH];
  logic [15:0] r_seq_mem  [DEPTH];
  logic [31:0] r_w0_mem   [DEPTH];
  logic [31:0] r_w1_mem   [DEPTH];
  logic [31:0] r_w2_mem   [DEPTH];

  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_seq;
  logic          r_overflow;
  logic [1:0]    r_beat, w_beat_nxt;

  logic          w_push, w_pop, w_end, w_more, w_last_pay;
  logic [2:0]    w_len;
  logic [31:0]   w_p0, w_p1, w_p2;
  logic [2:0]    w_h_type, w_h_len;
  logic [31:0]   w_hdr, w_pay;

`ifdef CHK_TRAILER_EN
  logic [31:0]   r_xor;
`endif

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot
  assign ev_ready   = (r_count < C_FULL);
  assign w_push     = ev_valid && ev_ready;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

  // Pack the payload words and length by event type at push time
  always_comb begin
    w_len = 3'd0;
    w_p0  = rs_value;
    w_p1  = rt_value;
    w_p2  = rd_value;
    case (ev_type)
      3'd0: w_len = 3'd3;
      3'd1: begin w_len = 3'd2; w_p1 = lw_data; end
      3'd2: w_len = 3'd2;
      3'd3: begin w_len = 3'd3; w_p2 = branch_addr; end
      3'd4: begin w_len = 3'd1; w_p0 = jump_addr; end
      default: w_len = 3'd0;
    endcase
  end

  // FIFO entry write; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_type_mem[r_wptr] <= ev_type;
      r_len_mem[r_wptr]  <= w_len;
      r_seq_mem[r_wptr]  <= r_seq;
      r_w0_mem[r_wptr]   <= w_p0;
      r_w1_mem[r_wptr]   <= w_p1;
      r_w2_mem[r_wptr]   <= w_p2;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequence number advances only on accepted events; any refused event sets overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq      <= 16'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_seq <= r_seq + 16'd1;
      if (ev_valid && !ev_ready) r_overflow <= 1'b1;
    end
  end

  assign w_h_type = r_type_mem[r_rptr];
  assign w_h_len  = r_len_mem[r_rptr];
  assign w_hdr    = {w_h_type, w_h_len, 10'd0, r_seq_mem[r_rptr]};
  assign w_pay    = (r_beat == 2'd0) ? r_w0_mem[r_rptr] :
                    (r_beat == 2'd1) ? r_w1_mem[r_rptr] : r_w2_mem[r_rptr];
  assign w_last_pay = ({1'b0, r_beat} == (w_h_len - 3'd1));
  // Entries that remain once the head is popped, counting a same-cycle push
  assign w_more   = (r_count > CW'(1)) || w_push;

  // Stream FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Stream FSM next state and beat outputs; head entry stays put until popped, so data holds on stall
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_end       = 1'b0;
    w_pop       = 1'b0;
    chk_valid   = 1'b0;
    chk_data    = 32'd0;
    chk_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) || w_push) w_state_nxt = S_HDR;
      end
      S_HDR: begin
        chk_valid = 1'b1;
        chk_data  = w_hdr;
`ifndef CHK_TRAILER_EN
        chk_last  = (w_h_len == 3'd0);
`endif
        if (chk_ready) begin
          if (w_h_len == 3'd0) begin
`ifdef CHK_TRAILER_EN
            w_state_nxt = S_TRL;
`else
            w_end = 1'b1;
`endif
          end else begin
            w_state_nxt = S_PAY;
            w_beat_nxt  = 2'd0;
          end
        end
      end
      S_PAY: begin
        chk_valid = 1'b1;
        chk_data  = w_pay;
`ifndef CHK_TRAILER_EN
        chk_last  = w_last_pay;
`endif
        if (chk_ready) begin
          w_beat_nxt = r_beat + 2'd1;
          if (w_last_pay) begin
`ifdef CHK_TRAILER_EN
            w_state_nxt = S_TRL;
`else
            w_end = 1'b1;
`endif
          end
        end
      end
`ifdef CHK_TRAILER_EN
      S_TRL: begin
        chk_valid = 1'b1;
        chk_data  = r_xor;
        chk_last  = 1'b1;
        if (chk_ready) w_end = 1'b1;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_end) begin
      w_pop       = 1'b1;
      w_state_nxt = w_more ? S_HDR : S_IDLE;
    end
  end

`ifdef CHK_TRAILER_EN
  // Running XOR of header and payload words accepted for the current event
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xor <= 32'd0;
    end else if (chk_ready) begin
      if (r_state == S_HDR)      r_xor <= w_hdr;
      else if (r_state == S_PAY) r_xor <= r_xor ^ w_pay;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_check_event_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_check_event_sequencer
// Description : Self-checking bench for check_event_sequencer: directed ALU
//               event, then randomized traffic against an event/beat queue model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_check_event_sequencer;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ev_valid = 1'b0;
  logic [2:0]    ev_type = 3'd0;
  logic [31:0]   rs_value = '0, rt_value = '0, rd_value = '0;
  logic [31:0]   branch_addr = '0, jump_addr = '0, lw_data = '0;
  logic          ev_ready;
  logic          chk_valid;
  logic [31:0]   chk_data;
  logic          chk_last;
  logic          chk_ready = 1'b0;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  check_event_sequencer #(.DEPTH(DEPTH)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .ev_valid    (ev_valid),
    .ev_type     (ev_type),
    .rs_value    (rs_value),
    .rt_value    (rt_value),
    .rd_value    (rd_value),
    .branch_addr (branch_addr),
    .jump_addr   (jump_addr),
    .lw_data     (lw_data),
    .ev_ready    (ev_ready),
    .chk_valid   (chk_valid),
    .chk_data    (chk_data),
    .chk_last    (chk_last),
    .chk_ready   (chk_ready),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: flat queue of expected beats {last, data}, plus queued event count
  logic [32:0] m_beats[$];
  int          m_events = 0;
  logic [15:0] m_seq = 16'd0;
  logic        m_ovf = 1'b0;

  function automatic void m_push_event(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt,
                                       input logic [31:0] rd, input logic [31:0] ba, input logic [31:0] ja,
                                       input logic [31:0] lw);
    logic [31:0] pay[$];
    logic [31:0] hdr;
    logic [31:0] x;
    bit          trl;
`ifdef CHK_TRAILER_EN
    trl = 1'b1;
`else
    trl = 1'b0;
`endif
    case (t)
      3'd0: begin pay.push_back(rs); pay.push_back(rt); pay.push_back(rd); end
      3'd1: begin pay.push_back(rs); pay.push_back(lw); end
      3'd2: begin pay.push_back(rs); pay.push_back(rt); end
      3'd3: begin pay.push_back(rs); pay.push_back(rt); pay.push_back(ba); end
      3'd4: pay.push_back(ja);
      default: ;
    endcase
    hdr = {t, 3'(pay.size()), 10'd0, m_seq};
    x   = hdr;
    m_beats.push_back({(!trl && pay.size() == 0), hdr});
    for (int i = 0; i < pay.size(); i++) begin
      x = x ^ pay[i];
      m_beats.push_back({(!trl && i == pay.size() - 1), pay[i]});
    end
    if (trl) m_beats.push_back({1'b1, x});
    m_events++;
    m_seq++;
  endfunction

  // One cycle: check outputs against the model, drive random inputs, advance the model across the edge
  task automatic cycle(input bit do_rst, input int pv, input int pr);
    bit push, xfer, drop;
    check_eq("chk_valid", 32'(chk_valid), 32'(m_beats.size() > 0));
    if (m_beats.size() > 0) begin
      check_eq("chk_data", chk_data, m_beats[0][31:0]);
      check_eq("chk_last", 32'(chk_last), 32'(m_beats[0][32]));
    end
    check_eq("ev_ready", 32'(ev_ready), 32'(m_events < DEPTH));
    check_eq("fifo_count", 32'(fifo_count), 32'(m_events));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));

    reset       = do_rst;
    ev_valid    = ($urandom_range(0, 99) < pv);
    ev_type     = 3'($urandom_range(0, 7));
    rs_value    = $urandom;
    rt_value    = $urandom;
    rd_value    = $urandom;
    branch_addr = $urandom;
    jump_addr   = $urandom;
    lw_data     = $urandom;
    chk_ready   = ($urandom_range(0, 99) < pr);

    push = ev_valid && (m_events < DEPTH);
    drop = ev_valid && (m_events >= DEPTH);
    xfer = chk_ready && (m_beats.size() > 0);

    @(posedge clk); #1;

    if (do_rst) begin
      m_beats.delete();
      m_events = 0;
      m_seq    = 16'd0;
      m_ovf    = 1'b0;
    end else begin
      if (xfer) begin
        if (m_beats[0][32]) m_events--;
        void'(m_beats.pop_front());
      end
      if (push) m_push_event(ev_type, rs_value, rt_value, rd_value, branch_addr, jump_addr, lw_data);
      if (drop) m_ovf = 1'b1;
    end
  endtask

  initial begin
    // Reset and check reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_chk_valid", 32'(chk_valid), 32'd0);
    check_eq("rst_chk_data", chk_data, 32'd0);
    check_eq("rst_chk_last", 32'(chk_last), 32'd0);
    check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
    check_eq("rst_ev_ready", 32'(ev_ready), 32'd1);
    check_eq("rst_overflow", 32'(overflow), 32'd0);

    // Directed ALU event, checker always ready
    ev_valid = 1'b1; ev_type = 3'd0;
    rs_value = 32'h11; rt_value = 32'h22; rd_value = 32'h33;
    chk_ready = 1'b1;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    check_eq("alu_hdr_valid", 32'(chk_valid), 32'd1);
    check_eq("alu_hdr", chk_data, 32'h0C000000);
    check_eq("alu_hdr_last", 32'(chk_last), 32'd0);
    @(posedge clk); #1;
    check_eq("alu_w0", chk_data, 32'h11);
    check_eq("alu_w0_last", 32'(chk_last), 32'd0);
    @(posedge clk); #1;
    check_eq("alu_w1", chk_data, 32'h22);
    @(posedge clk); #1;
    check_eq("alu_w2", chk_data, 32'h33);
`ifdef CHK_TRAILER_EN
    check_eq("alu_w2_last", 32'(chk_last), 32'd0);
    @(posedge clk); #1;
    check_eq("alu_trl", chk_data, 32'h0C000000);
    check_eq("alu_trl_last", 32'(chk_last), 32'd1);
`else
    check_eq("alu_w2_last", 32'(chk_last), 32'd1);
`endif
    @(posedge clk); #1;
    check_eq("alu_done_valid", 32'(chk_valid), 32'd0);
    check_eq("alu_done_count", 32'(fifo_count), 32'd0);

    // Model now tracks the DUT: empty FIFO, one event already sequenced
    m_seq = 16'd1;

    // Mixed traffic, mostly-ready checker
    for (int i = 0; i < 400; i++) cycle(1'b0, 60, 80);
    // Heavy retire rate with a slow checker: fills the FIFO and drops events
    for (int i = 0; i < 300; i++) cycle(1'b0, 90, 10);
    // Light traffic with occasional resets landing mid-event
    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 99) < 2, 30, 70);
    // Bursty stalls
    for (int i = 0; i < 300; i++) cycle(1'b0, 70, 40);
    // Drain
    for (int i = 0; i < 60; i++) cycle(1'b0, 0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
